piso_tx: RTL and testbench
==========================

# piso_tx

Parallel-in serial-out transmitter: accepts a WIDTH-bit parallel word through a valid/ready handshake and shifts it out one bit per enabled clock, MSB first. It is the serializing counterpart to the parallel capture registers in the shift-register library. It sits between a parallel data source and a serial link or downstream SIPO receiver, with a stall input for link pacing.

## Interface
- WIDTH, 4: data word width in bits, at least 2.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in  input  WIDTH  parallel word to transmit.
- in_valid  input  1  source has a word on `in`.
- in_ready  output  1  block accepts `in` on this edge.
- ser_en  input  1  link advance strobe; the current bit is consumed on an edge where ser_en=1.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out holds a frame bit.
- ser_last  output  1  ser_out is the final bit of the frame.
- busy  output  1  frame in progress; equals ser_valid.

## Operation
- State: IDLE and SHIFT. Internal shift register `sreg` is WIDTH (+1 with parity) bits wide. The bit counter is wide enough for the frame length.
- Accept: an edge with in_valid=1 and in_ready=1 accepts the word.
- in_ready is combinational: !rst && (state==IDLE || (ser_last && ser_en)).
- On accept, `sreg` loads `in`, the counter loads the frame length minus 1, and state moves to SHIFT.
- SHIFT: ser_out=sreg MSB. On an edge with ser_en=1:
  - if not last, `sreg` shifts left by one and zero-fills, and the counter decrements;
  - if last and a new word is accepted on the same edge, the block reloads and stays in SHIFT (back-to-back, no gap);
  - if last and no word is accepted, the block goes to IDLE.
- ser_en=0 in SHIFT holds all state and outputs (stall). in_valid is ignored in SHIFT unless ser_last && ser_en.
- ser_en in IDLE has no effect.
- ser_last is 1 exactly when the counter is 0 in SHIFT.
- Reset: rst=1 at an edge forces IDLE, sreg=0, and counter=0, regardless of any in-progress frame or a simultaneous accept. The partial frame is discarded with no completion indication.
- Reset values, registered from the first edge with rst=1: ser_out=0, ser_valid=0, ser_last=0, busy=0. in_ready=0 while rst=1.

## Timing
- Latency: a word accepted at edge N gives its MSB on ser_out after edge N, valid for cycle N+1.
- Frame length L = WIDTH, or WIDTH+1 with parity. With ser_en held at 1, bit k appears in cycle N+1+k and ser_last is high in cycle N+L.
- Throughput: with ser_en=1 continuously and in_valid=1, one word every L cycles with no idle cycle between frames.
- Stall: each ser_en=0 cycle extends the frame by exactly one cycle. No bit is dropped or duplicated.
- ser_out, ser_valid, ser_last, and busy are registered and change only on rising edges of clk.

## Configuration
- PISO_PARITY_EN defined:
  - the frame is WIDTH+1 bits, with an even-parity bit (XOR of all WIDTH data bits) appended after the LSB;
  - ser_last flags the parity bit;
  - parity is computed from `in` at accept time.
- PISO_PARITY_EN undefined: the frame is WIDTH data bits only, ser_last flags the LSB, and no parity logic is present.

## Test plan
- Reset then single word: rst=1 for 2 cycles, then in=4'b1011 with in_valid=1 for 1 cycle and ser_en=1 -> ser_out 1,0,1,1 in cycles N+1..N+4, ser_last only in N+4, and ser_valid drops in N+5. Required: in_ready=0 during reset and 1 in IDLE.
- Stall: as above, with ser_en=0 during cycles N+2 and N+3 -> ser_out sequence 1,0,0,0,1,1 with the held value repeated, ser_last only on the final 1, and frame length 6 cycles.
- Back-to-back: in_valid held at 1 with 4'b1011 then 4'b0110, ser_en=1 -> ser_out 1,0,1,1,0,1,1,0 with no gap. in_ready=1 only in IDLE and on each ser_last cycle, and ser_last pulses in cycles N+4 and N+8.
- Reset mid-frame: rst=1 at the edge after the 2nd bit of 4'b1011, with in_valid=1 on the same edge -> ser_valid=0 and ser_out=0 next cycle, the word is not accepted, and after rst=0 a new word 4'b0001 serializes cleanly as 0,0,0,1.
- Parity (PISO_PARITY_EN defined): in=4'b1011 -> ser_out 1,0,1,1,1 with ser_last on the 5th bit. in=4'b0110 -> 0,1,1,0,0.
- Idle robustness: in_valid=0 with ser_en toggling randomly for 20 cycles after reset -> ser_valid, ser_out, and busy stay 0, and in_ready stays 1.

Source files
------------

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, MSB first, valid/ready input
// handshake and a ser_en advance strobe for link pacing.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit after the LSB.
//
// state | meaning
// IDLE  | no frame in progress, ready for a word
// SHIFT | frame in progress, sreg MSB is on ser_out
module piso_tx #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             ser_en,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_last,
   output logic             busy
);

`ifdef PISO_PARITY_EN
   localparam int FL = WIDTH + 1;
`else
   localparam int FL = WIDTH;
`endif
   localparam int CW = (FL > 2) ? $clog2(FL) : 1;

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t          state;
   logic [FL-1:0]   sreg;
   logic [CW-1:0]   cnt;
   logic            last;
   logic            accept;
   logic [FL-1:0]   frame;

   // Frame image loaded on accept; parity is taken from the word as it arrives.
`ifdef PISO_PARITY_EN
   assign frame = {in, ^in};
`else
   assign frame = in;
`endif

   // Ready in IDLE, or on the edge that consumes the final bit (back-to-back).
   assign in_ready = !rst && ((state == IDLE) || (last && ser_en));
   assign accept   = in_valid && in_ready;

   assign ser_out   = sreg[FL-1];
   assign ser_valid = (state == SHIFT);
   assign busy      = (state == SHIFT);
   assign ser_last  = last;

   // Frame sequencer: load, shift on ser_en, finish or reload on the last bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sreg  <= '0;
         cnt   <= '0;
         last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= SHIFT;
                  sreg  <= frame;
                  cnt   <= CW'(FL - 1);
                  last  <= 1'b0;
               end
            end
            SHIFT: begin
               if (ser_en) begin
                  if (last) begin
                     if (accept) begin
                        sreg <= frame;
                        cnt  <= CW'(FL - 1);
                        last <= 1'b0;
                     end else begin
                        // Shifting out the final bit leaves sreg all-zero,
                        // so ser_out idles low.
                        state <= IDLE;
                        sreg  <= {sreg[FL-2:0], 1'b0};
                        last  <= 1'b0;
                     end
                  end else begin
                     sreg <= {sreg[FL-2:0], 1'b0};
                     cnt  <= cnt - CW'(1);
                     last <= (cnt == CW'(1));
                  end
               end
            end
            default: begin
               state <= IDLE;
               sreg  <= '0;
               cnt   <= '0;
               last  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: directed vector table, hand-written
// corner sequences, and randomized traffic against a bit-queue model.
module tb_piso_tx;

   localparam int W = 4;
`ifdef PISO_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif

   logic         clk;
   logic         rst;
   logic [W-1:0] din;
   logic         in_valid;
   logic         in_ready;
   logic         ser_en;
   logic         ser_out;
   logic         ser_valid;
   logic         ser_last;
   logic         busy;

   int pass_cnt = 0;
   int total_cnt = 0;

   piso_tx #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in        (din),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ser_en    (ser_en),
      .ser_out   (ser_out),
      .ser_valid (ser_valid),
      .ser_last  (ser_last),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         r;
      logic [W-1:0] d;
      logic         iv;
      logic         en;
      logic         rdy;
      logic         o;
      logic         v;
      logic         l;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic act, input logic exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
   endtask

   task automatic add(input logic r, input logic [W-1:0] d, input logic iv,
                      input logic en, input logic rdy, input logic o,
                      input logic v, input logic l);
      vec_t t;
      t.r = r; t.d = d; t.iv = iv; t.en = en;
      t.rdy = rdy; t.o = o; t.v = v; t.l = l;
      vecs.push_back(t);
   endtask

   // One cycle: drive, check in_ready, clock, check registered outputs.
   task automatic step(input logic r, input logic [W-1:0] d, input logic iv,
                       input logic en, output logic rdy_s, output logic o_s,
                       output logic v_s, output logic l_s, output logic b_s);
      @(negedge clk);
      rst = r; din = d; in_valid = iv; ser_en = en;
      #1 rdy_s = in_ready;
      @(posedge clk);
      #1;
      o_s = ser_out; v_s = ser_valid; l_s = ser_last; b_s = busy;
   endtask

   // Reference model: remaining frame bits, front is the bit on ser_out.
   logic mq[$];

   task automatic push_frame(input logic [W-1:0] d);
      for (int i = W - 1; i >= 0; i--) mq.push_back(d[i]);
`ifdef PISO_PARITY_EN
      mq.push_back(^d);
`endif
   endtask

   initial begin
      logic rs, os, vs, ls, bs;
      logic mrdy;
      logic [W-1:0] rd;
      logic rr, riv, ren;
      logic bits[$];

      rst = 1'b1; din = '0; in_valid = 1'b0; ser_en = 1'b0;

`ifndef PISO_PARITY_EN
      // reset, single word
      add(1, 4'b0000, 0, 1, 0, 0, 0, 0);
      add(1, 4'b0000, 0, 1, 0, 0, 0, 0);
      add(0, 4'b1011, 1, 1, 1, 1, 1, 0);
      add(0, 4'b0000, 0, 1, 0, 0, 1, 0);
      add(0, 4'b0000, 0, 1, 0, 1, 1, 0);
      add(0, 4'b0000, 0, 1, 0, 1, 1, 1);
      add(0, 4'b0000, 0, 1, 1, 0, 0, 0);
      add(0, 4'b0000, 0, 1, 1, 0, 0, 0);
      // stall for two cycles
      add(0, 4'b1011, 1, 1, 1, 1, 1, 0);
      add(0, 4'b0000, 0, 1, 0, 0, 1, 0);
      add(0, 4'b0000, 0, 0, 0, 0, 1, 0);
      add(0, 4'b0000, 0, 0, 0, 0, 1, 0);
      add(0, 4'b0000, 0, 1, 0, 1, 1, 0);
      add(0, 4'b0000, 0, 1, 0, 1, 1, 1);
      add(0, 4'b0000, 0, 1, 1, 0, 0, 0);
      // back-to-back
      add(0, 4'b1011, 1, 1, 1, 1, 1, 0);
      add(0, 4'b0110, 1, 1, 0, 0, 1, 0);
      add(0, 4'b0110, 1, 1, 0, 1, 1, 0);
      add(0, 4'b0110, 1, 1, 0, 1, 1, 1);
      add(0, 4'b0110, 1, 1, 1, 0, 1, 0);
      add(0, 4'b0000, 0, 1, 0, 1, 1, 0);
      add(0, 4'b0000, 0, 1, 0, 1, 1, 0);
      add(0, 4'b0000, 0, 1, 0, 0, 1, 1);
      add(0, 4'b0000, 0, 1, 1, 0, 0, 0);
      // reset mid-frame with simultaneous valid
      add(0, 4'b1011, 1, 1, 1, 1, 1, 0);
      add(0, 4'b0000, 0, 1, 0, 0, 1, 0);
      add(1, 4'b0001, 1, 1, 0, 0, 0, 0);
      add(0, 4'b0001, 1, 1, 1, 0, 1, 0);
      add(0, 4'b0000, 0, 1, 0, 0, 1, 0);
      add(0, 4'b0000, 0, 1, 0, 0, 1, 0);
      add(0, 4'b0000, 0, 1, 0, 1, 1, 1);
      add(0, 4'b0000, 0, 1, 1, 0, 0, 0);

      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].d, vecs[i].iv, vecs[i].en, rs, os, vs, ls, bs);
         check($sformatf("vec%0d in_ready", i), rs, vecs[i].rdy);
         check($sformatf("vec%0d ser_out", i), os, vecs[i].o);
         check($sformatf("vec%0d ser_valid", i), vs, vecs[i].v);
         check($sformatf("vec%0d ser_last", i), ls, vecs[i].l);
         check($sformatf("vec%0d busy", i), bs, vecs[i].v);
      end
`else
      // parity frames: 1011 -> 1,0,1,1,1 and 0110 -> 0,1,1,0,0
      step(1, '0, 0, 1, rs, os, vs, ls, bs);
      check("par rst ready", rs, 1'b0);
      for (int f = 0; f < 2; f++) begin
         logic [W-1:0] w;
         logic [FL-1:0] exp;
         w   = (f == 0) ? 4'b1011 : 4'b0110;
         exp = (f == 0) ? 5'b10111 : 5'b01100;
         step(0, w, 1, 1, rs, os, vs, ls, bs);
         check("par accept ready", rs, 1'b1);
         for (int k = 0; k < FL; k++) begin
            check($sformatf("par%0d bit%0d", f, k), os, exp[FL-1-k]);
            check($sformatf("par%0d valid%0d", f, k), vs, 1'b1);
            check($sformatf("par%0d last%0d", f, k), ls, (k == FL - 1));
            step(0, '0, 0, 1, rs, os, vs, ls, bs);
         end
         check($sformatf("par%0d end valid", f), vs, 1'b0);
      end
`endif

      // idle robustness: random ser_en, no valid
      step(1, '0, 0, 0, rs, os, vs, ls, bs);
      for (int i = 0; i < 20; i++) begin
         step(0, W'($urandom), 0, 1'($urandom), rs, os, vs, ls, bs);
         check($sformatf("idle%0d in_ready", i), rs, 1'b1);
         check($sformatf("idle%0d ser_out", i), os, 1'b0);
         check($sformatf("idle%0d ser_valid", i), vs, 1'b0);
         check($sformatf("idle%0d busy", i), bs, 1'b0);
      end

      // randomized traffic against the bit-queue model
      mq.delete();
      for (int i = 0; i < 400; i++) begin
         rr  = (i == 0) || ($urandom_range(0, 49) == 0);
         riv = 1'($urandom_range(0, 1));
         ren = ($urandom_range(0, 9) < 7);
         rd  = W'($urandom);
         mrdy = !rr && ((mq.size() == 0) || (mq.size() == 1 && ren));
         if (rr) mq.delete();
         else begin
            if (mq.size() > 0 && ren) void'(mq.pop_front());
            if (riv && mrdy) push_frame(rd);
         end
         step(rr, rd, riv, ren, rs, os, vs, ls, bs);
         check($sformatf("rnd%0d in_ready", i), rs, mrdy);
         check($sformatf("rnd%0d ser_valid", i), vs, mq.size() > 0);
         check($sformatf("rnd%0d ser_out", i), os, (mq.size() > 0) ? mq[0] : 1'b0);
         check($sformatf("rnd%0d ser_last", i), ls, mq.size() == 1);
         check($sformatf("rnd%0d busy", i), bs, mq.size() > 0);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish, passed %0d of %0d", pass_cnt, total_cnt);
      $fatal(1);
   end

endmodule
